// File: rtl/uart_csr_pkg.sv
// uart_csr_pkg: shared constants for the UART CSR block.
//   - CSR byte offsets (DATA, STATUS, CONTROL, DIVISOR)
//   - STATUS and CONTROL bit positions
//   - default reset value of the baud divisor
package uart_csr_pkg;

  localparam logic [3:0] CSR_DATA    = 4'h0;
  localparam logic [3:0] CSR_STATUS  = 4'h4;
  localparam logic [3:0] CSR_CONTROL = 4'h8;
  localparam logic [3:0] CSR_DIVISOR = 4'hC;

  localparam int ST_TX_FULL     = 0;
  localparam int ST_TX_EMPTY    = 1;
  localparam int ST_RX_FULL     = 2;
  localparam int ST_RX_EMPTY    = 3;
  localparam int ST_RX_OVERRUN  = 4;
  localparam int ST_TX_OVERFLOW = 5;

  localparam int CTRL_TX_EN  = 0;
  localparam int CTRL_RX_EN  = 1;
  localparam int CTRL_IE_RX  = 2;
  localparam int CTRL_IE_TXE = 3;

  localparam logic [15:0] DIV_RESET_DEFAULT = 16'd27;

endpackage

// File: rtl/uart_csr_if.sv
// uart_csr_if: BRAM-style CSR access bus between the AXI-lite slave and uart_csr.
//   bram_addr/bram_wr/bram_wr_data/bram_rd driven by the master (upstream),
//   bram_rd_data returned by the slave one cycle after bram_rd.
interface uart_csr_if #(
  parameter int ADD_WIDTH = 8
) ();
  logic [ADD_WIDTH-1:0] bram_addr;
  logic                 bram_wr;
  logic [31:0]          bram_wr_data;
  logic                 bram_rd;
  logic [31:0]          bram_rd_data;

  modport master (
    output bram_addr, bram_wr, bram_wr_data, bram_rd,
    input  bram_rd_data
  );

  modport slave (
    input  bram_addr, bram_wr, bram_wr_data, bram_rd,
    output bram_rd_data
  );
endinterface

// File: rtl/uart_csr_fifo.sv
// uart_csr_fifo: synchronous FIFO with combinational head output.
//   clk, rst      clock, synchronous active-high reset (flushes pointers/count)
//   push/push_data write side; a push while full is accepted only if a pop
//                 happens in the same cycle
//   pop/pop_data  read side; pop_data is the current head, pop ignored when empty
//   full/empty/count occupancy
module uart_csr_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign do_pop   = pop & ~empty;
  // A same-cycle pop frees the slot, so a push while full still goes in.
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is pure data: no reset needed, occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/uart_csr.sv
// uart_csr: CSR register file plus TX/RX byte FIFOs for the UART.
//   aclk, areset  clock, synchronous active-high reset
//   bus           BRAM-style CSR access (slave side), read data registered
//   tx_data/tx_valid/tx_ready  byte stream to the serializer
//   rx_data/rx_valid           byte push from the deserializer (no backpressure)
//   baud_div, tx_en, rx_en     register outputs
//   irq           registered level interrupt
module uart_csr
  import uart_csr_pkg::*;
#(
  parameter int          ADD_WIDTH  = 8,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] DIV_RESET  = DIV_RESET_DEFAULT
) (
  input  logic        aclk,
  input  logic        areset,
  uart_csr_if.slave   bus,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [15:0] baud_div,
  output logic        tx_en,
  output logic        rx_en,
  output logic        irq
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [1:0] SEL_DATA    = CSR_DATA[3:2];
  localparam logic [1:0] SEL_STATUS  = CSR_STATUS[3:2];
  localparam logic [1:0] SEL_CONTROL = CSR_CONTROL[3:2];
  localparam logic [1:0] SEL_DIVISOR = CSR_DIVISOR[3:2];

  logic [3:0]    ctrl_q, ctrl_d;
  logic [15:0]   div_q, div_d;
  logic          rx_ovr_q, rx_ovr_d;
  logic          tx_ovf_q, tx_ovf_d;
  logic [31:0]   rd_data_q, rd_data_d;
  logic          irq_q, irq_d;

  logic          mapped, wr_hit, rd_hit;
  logic [1:0]    sel;
  logic [31:0]   wd, rd_value;
  logic          tx_push, tx_pop, tx_full, tx_empty;
  logic          rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]    tx_head, rx_head;
  logic [CW-1:0] tx_count, rx_count;
  logic          unused_bits;

  assign wd     = bus.bram_wr_data;
  assign sel    = bus.bram_addr[3:2];
  assign mapped = (bus.bram_addr[ADD_WIDTH-1:4] == '0);
  assign wr_hit = bus.bram_wr & mapped;
  // The write wins a collision, so the read has no side effect then.
  assign rd_hit = bus.bram_rd & ~bus.bram_wr & mapped;

  assign unused_bits = ^{bus.bram_addr[1:0], wd[31:16]};

  assign tx_push  = wr_hit & (sel == SEL_DATA);
  assign tx_valid = ctrl_q[CTRL_TX_EN] & ~tx_empty;
  assign tx_pop   = tx_valid & tx_ready;
  assign tx_data  = tx_empty ? 8'h00 : tx_head;

  assign rx_push  = rx_valid & ctrl_q[CTRL_RX_EN];
  assign rx_pop   = rd_hit & (sel == SEL_DATA);

  uart_csr_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (aclk),
    .rst       (areset),
    .push      (tx_push),
    .push_data (wd[7:0]),
    .pop       (tx_pop),
    .pop_data  (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  uart_csr_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (aclk),
    .rst       (areset),
    .push      (rx_push),
    .push_data (rx_data),
    .pop       (rx_pop),
    .pop_data  (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count)
  );

  always_comb begin
    rd_value = '0;
    if (mapped) begin
      case (sel)
        SEL_DATA:    rd_value = rx_empty ? 32'h0 : {24'h0, rx_head};
        SEL_STATUS: begin
          rd_value[ST_TX_FULL]     = tx_full;
          rd_value[ST_TX_EMPTY]    = tx_empty;
          rd_value[ST_RX_FULL]     = rx_full;
          rd_value[ST_RX_EMPTY]    = rx_empty;
          rd_value[ST_RX_OVERRUN]  = rx_ovr_q;
          rd_value[ST_TX_OVERFLOW] = tx_ovf_q;
          rd_value[15:8]           = 8'(tx_count);
          rd_value[23:16]          = 8'(rx_count);
        end
        SEL_CONTROL: rd_value = {28'h0, ctrl_q};
        SEL_DIVISOR: rd_value = {16'h0, div_q};
        default:     rd_value = '0;
      endcase
    end
  end

  always_comb begin
    ctrl_d    = ctrl_q;
    div_d     = div_q;
    rx_ovr_d  = rx_ovr_q;
    tx_ovf_d  = tx_ovf_q;
    rd_data_d = rd_data_q;
    if (wr_hit) begin
      case (sel)
        SEL_STATUS: begin
          if (wd[ST_RX_OVERRUN])  rx_ovr_d = 1'b0;
          if (wd[ST_TX_OVERFLOW]) tx_ovf_d = 1'b0;
        end
        SEL_CONTROL: ctrl_d = wd[3:0];
        SEL_DIVISOR: div_d  = wd[15:0];
        default: ;
      endcase
    end
    // Sticky sets come after the W1C clear so a coincident set wins.
    if (tx_push & tx_full & ~tx_pop) tx_ovf_d = 1'b1;
    if (rx_push & rx_full & ~rx_pop) rx_ovr_d = 1'b1;
    if (bus.bram_rd) rd_data_d = bus.bram_wr ? 32'h0 : rd_value;
  end

  assign irq_d = (ctrl_q[CTRL_IE_RX] & ~rx_empty) | (ctrl_q[CTRL_IE_TXE] & tx_empty);

  always_ff @(posedge aclk) begin
    if (areset) begin
      ctrl_q    <= '0;
      div_q     <= DIV_RESET;
      rx_ovr_q  <= 1'b0;
      tx_ovf_q  <= 1'b0;
      rd_data_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      div_q     <= div_d;
      rx_ovr_q  <= rx_ovr_d;
      tx_ovf_q  <= tx_ovf_d;
      rd_data_q <= rd_data_d;
      irq_q     <= irq_d;
    end
  end

  assign bus.bram_rd_data = rd_data_q;
  assign baud_div         = div_q;
  assign tx_en            = ctrl_q[CTRL_TX_EN];
  assign rx_en            = ctrl_q[CTRL_RX_EN];
  assign irq              = irq_q;

endmodule

// File: tb/tb_uart_csr.sv
// tb_uart_csr: directed scoreboard bench for uart_csr.
//   Reads push their expected data into a queue; a monitor pops and compares
//   when the registered read data appears. TX bytes are scoreboarded the same
//   way on every tx_valid&tx_ready handshake.
module tb_uart_csr;
  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [15:0] baud_div;
  logic        tx_en, rx_en, irq;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  string       nm_q[$];
  logic [7:0]  tx_exp_q[$];
  logic        rd_seen = 1'b0;

  uart_csr_if #(.ADD_WIDTH(8)) bus ();

  uart_csr #(.ADD_WIDTH(8), .FIFO_DEPTH(16), .DIV_RESET(16'd27)) dut (
    .aclk     (clk),
    .areset   (areset),
    .bus      (bus),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .baud_div (baud_div),
    .tx_en    (tx_en),
    .rx_en    (rx_en),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Read data is valid in the cycle after the edge that sampled bram_rd.
  always @(posedge clk) rd_seen <= bus.bram_rd;

  always @(negedge clk) begin
    if (rd_seen) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_unexpected: got 0x%08h expected none", bus.bram_rd_data);
      end else begin
        chk(nm_q.pop_front(), bus.bram_rd_data, exp_q.pop_front());
      end
    end
    if (tx_valid && tx_ready) begin
      if (tx_exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL tx_unexpected: got 0x%02h expected none", tx_data);
      end else begin
        chk("tx_byte", {24'h0, tx_data}, {24'h0, tx_exp_q.pop_front()});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bus.bram_addr    = a;
    bus.bram_wr_data = d;
    bus.bram_wr      = 1'b1;
    cyc();
    bus.bram_wr      = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string nm);
    exp_q.push_back(exp);
    nm_q.push_back(nm);
    bus.bram_addr = a;
    bus.bram_rd   = 1'b1;
    cyc();
    bus.bram_rd   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.bram_addr    = '0;
    bus.bram_wr      = 1'b0;
    bus.bram_wr_data = '0;
    bus.bram_rd      = 1'b0;
    repeat (3) cyc();
    areset = 1'b0;

    // Reset state
    chk("rst_irq",      {31'h0, irq},      32'h0);
    chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("rst_tx_data",  {24'h0, tx_data},  32'h0);
    chk("rst_baud_div", {16'h0, baud_div}, 32'h1B);
    chk("rst_en",       {30'h0, tx_en, rx_en}, 32'h0);
    chk("rst_rd_data",  bus.bram_rd_data,  32'h0);
    rd(8'h04, 32'h0000_000A, "rst_status");
    rd(8'h0C, 32'h0000_001B, "rst_divisor");

    // TX stream
    wr(8'h08, 32'h1);
    wr(8'h00, 32'h41); tx_exp_q.push_back(8'h41);
    wr(8'h00, 32'h42); tx_exp_q.push_back(8'h42);
    wr(8'h00, 32'h43); tx_exp_q.push_back(8'h43);
    rd(8'h04, 32'h0000_0308, "tx3_status");
    chk("tx_head",  {24'h0, tx_data},  32'h41);
    chk("tx_valid_held", {31'h0, tx_valid}, 32'h1);
    tx_ready = 1'b1;
    repeat (3) cyc();
    chk("tx_drained_valid", {31'h0, tx_valid}, 32'h0);
    chk("tx_drained_q", tx_exp_q.size(), 32'h0);
    tx_ready = 1'b0;

    // RX overrun
    wr(8'h08, 32'h3);
    for (int i = 0; i < 17; i++) begin
      rx_data  = 8'(i);
      rx_valid = 1'b1;
      cyc();
    end
    rx_valid = 1'b0;
    rd(8'h04, 32'h0010_0016, "rx_full_status");
    for (int i = 0; i < 16; i++) rd(8'h00, 32'(i), "rx_drain");
    rd(8'h00, 32'h0, "rx_empty_read");
    rd(8'h04, 32'h0000_001A, "rx_overrun_status");
    wr(8'h04, 32'h10);
    rd(8'h04, 32'h0000_000A, "rx_w1c_status");

    // RX interrupt
    wr(8'h08, 32'h7);
    rx_data  = 8'h55;
    rx_valid = 1'b1;
    cyc();
    rx_valid = 1'b0;
    cyc();
    chk("irq_rx_set", {31'h0, irq}, 32'h1);
    rd(8'h00, 32'h55, "irq_rx_byte");
    cyc();
    chk("irq_rx_clear", {31'h0, irq}, 32'h0);

    // RX full, push coincident with DATA read
    for (int i = 0; i < 16; i++) begin
      rx_data  = 8'h80 + 8'(i);
      rx_valid = 1'b1;
      cyc();
    end
    rx_data  = 8'hAA;
    rx_valid = 1'b1;
    rd(8'h00, 32'h80, "rx_coinc_head");
    rx_valid = 1'b0;
    rd(8'h04, 32'h0010_0006, "rx_coinc_status");
    for (int i = 1; i < 16; i++) rd(8'h00, 32'h80 + 32'(i), "rx_coinc_drain");
    rd(8'h00, 32'hAA, "rx_coinc_pushed");
    rd(8'h04, 32'h0000_000A, "rx_coinc_empty");

    // Divisor, control readback, unmapped access
    wr(8'h0C, 32'hFFFF_1234);
    chk("baud_div_out", {16'h0, baud_div}, 32'h1234);
    rd(8'h0C, 32'h0000_1234, "divisor_rd");
    wr(8'h1C, 32'h0000_ABCD);
    rd(8'h1C, 32'h0, "unmapped_rd");
    rd(8'h0C, 32'h0000_1234, "divisor_after_unmapped");
    wr(8'h08, 32'hFFFF_FFF8);
    rd(8'h08, 32'h8, "control_rd");
    chk("irq_txe", {31'h0, irq}, 32'h1);

    // TX overflow and reset mid-stream
    wr(8'h08, 32'h0);
    for (int i = 0; i < 16; i++) wr(8'h00, 32'(i) + 32'h60);
    wr(8'h00, 32'h77);
    rd(8'h04, 32'h0000_1029, "tx_overflow_status");
    chk("tx_gated_valid", {31'h0, tx_valid}, 32'h0);
    wr(8'h08, 32'h1);
    chk("tx_enabled_valid", {31'h0, tx_valid}, 32'h1);
    chk("tx_enabled_head",  {24'h0, tx_data},  32'h60);
    areset = 1'b1;
    cyc();
    areset = 1'b0;
    chk("post_rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("post_rst_baud_div", {16'h0, baud_div}, 32'h1B);
    rd(8'h04, 32'h0000_000A, "post_rst_status");
    rd(8'h08, 32'h0, "post_rst_control");
    cyc();
    chk("post_rst_irq", {31'h0, irq}, 32'h0);
    chk("rd_queue_empty", exp_q.size(), 32'h0);
    chk("tx_queue_empty", tx_exp_q.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
